// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path: FSM state encoding,
// legal parameter ranges and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  localparam int DATA_BITS_MIN  = 5;
  localparam int DATA_BITS_MAX  = 9;
  localparam int OVERSAMPLE_MIN = 8;
  localparam int OVERSAMPLE_MAX = 32;

  // Data is zero-extended to DATA_BITS_MAX by the caller; the extra zeros do not change the XOR.
  function automatic logic parity_bit(input logic [DATA_BITS_MAX-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an idle-high serial line; resets to 1 so that
// reset release never looks like a falling edge.
module uart_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] r_sync;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sync <= 2'b11;
    else       r_sync <= {r_sync[0], i_d};
  end

  assign o_q = r_sync[1];

endmodule

// File: rtl/uart_rx_os.sv
// Oversampled UART receiver with mid-bit sampling, false-start rejection and a valid/ready output.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority voting around each mid-bit sample.
import uart_pkg::*;

module uart_rx_os #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 os_tick,
  input  logic                 rxd,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 stop2,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_parity_err,
  output logic                 m_frame_err,
  output logic                 overrun,
  output logic                 break_det
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] BIT_DEC = CNT_W'(OVERSAMPLE - 1);

  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
    $error("uart_rx_os: DATA_BITS out of range");
  end
  if (OVERSAMPLE < OVERSAMPLE_MIN || OVERSAMPLE > OVERSAMPLE_MAX || (OVERSAMPLE % 2) != 0) begin : g_bad_os
    $error("uart_rx_os: OVERSAMPLE out of range or odd");
  end

  logic w_rxd_s;
  logic w_bit;

  uart_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (rxd),
    .o_q   (w_rxd_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // The start decision moves one tick later; the counter then restarts at mid+1, so every
  // later window (OS-3..OS-1) stays centred on its bit.
  localparam logic [CNT_W-1:0] START_DEC = CNT_W'(OVERSAMPLE / 2);
  logic [1:0] r_hist;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        r_hist <= 2'b11;
    else if (os_tick) r_hist <= {r_hist[0], w_rxd_s};
  end

  assign w_bit = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_rxd_s) | (r_hist[0] & w_rxd_s);
`else
  localparam logic [CNT_W-1:0] START_DEC = CNT_W'(OVERSAMPLE / 2 - 1);
  assign w_bit = w_rxd_s;
`endif

  rx_state_t            r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [BIT_W-1:0]     r_bit_idx;
  logic                 r_stop_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_en, r_par_odd, r_stop2;
  logic                 r_par_err, r_par_zero, r_ferr;

  logic [DATA_BITS_MAX-1:0] w_data_ext;
  logic                     w_ferr;
  logic                     w_break;

  assign w_data_ext = DATA_BITS_MAX'(r_shift);
  assign w_ferr     = r_ferr | ~w_bit;
  // r_par_zero stays 1 when no parity bit is present, so it only vetoes a break on a high parity sample.
  assign w_break    = w_ferr & (r_shift == '0) & r_par_zero;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_bit_idx    <= '0;
      r_stop_idx   <= 1'b0;
      r_shift      <= '0;
      r_par_en     <= 1'b0;
      r_par_odd    <= 1'b0;
      r_stop2      <= 1'b0;
      r_par_err    <= 1'b0;
      r_par_zero   <= 1'b1;
      r_ferr       <= 1'b0;
      m_data       <= '0;
      m_valid      <= 1'b0;
      m_parity_err <= 1'b0;
      m_frame_err  <= 1'b0;
      overrun      <= 1'b0;
      break_det    <= 1'b0;
    end else begin
      overrun   <= 1'b0;
      break_det <= 1'b0;
      if (m_valid && m_ready) m_valid <= 1'b0;

      if (os_tick) begin
        case (r_state)
          IDLE: if (!w_rxd_s) begin
            r_state   <= START;
            r_cnt     <= '0;
            r_par_en  <= parity_en;
            r_par_odd <= parity_odd;
            r_stop2   <= stop2;
          end
          START: if (r_cnt == START_DEC) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_state   <= w_bit ? IDLE : DATA;
          end else r_cnt <= r_cnt + 1'b1;
          DATA: if (r_cnt == BIT_DEC) begin
            r_cnt   <= '0;
            r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
            if (r_bit_idx == BIT_W'(DATA_BITS - 1)) begin
              r_state    <= r_par_en ? PARITY : STOP;
              r_stop_idx <= 1'b0;
              r_ferr     <= 1'b0;
              r_par_err  <= 1'b0;
              r_par_zero <= 1'b1;
            end else r_bit_idx <= r_bit_idx + 1'b1;
          end else r_cnt <= r_cnt + 1'b1;
          PARITY: if (r_cnt == BIT_DEC) begin
            r_cnt      <= '0;
            r_par_err  <= w_bit != parity_bit(w_data_ext, r_par_odd);
            r_par_zero <= ~w_bit;
            r_state    <= STOP;
          end else r_cnt <= r_cnt + 1'b1;
          STOP: if (r_cnt == BIT_DEC) begin
            r_cnt <= '0;
            if (r_stop_idx == r_stop2) begin
              // Completion: a held word is replaced only if it is being accepted this cycle.
              if (!m_valid || m_ready) begin
                m_data       <= r_shift;
                m_parity_err <= r_par_err;
                m_frame_err  <= w_ferr;
                m_valid      <= 1'b1;
              end else overrun <= 1'b1;
              break_det <= w_break;
              r_state   <= w_ferr ? WAIT_IDLE : IDLE;
            end else begin
              r_stop_idx <= 1'b1;
              r_ferr     <= w_ferr;
            end
          end else r_cnt <= r_cnt + 1'b1;
          WAIT_IDLE: if (w_rxd_s) r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Parametrised, oversampled UART receiver; the next-generation RX for the serial subsystem. It replaces single-tick-per-bit sampling with N× oversampling, mid-bit sampling and false-start rejection. Data width, parity mode and stop-bit count are configurable. It sits between the shared baud generator, which supplies an oversample tick, and the consumer, which takes words through a valid/ready handshake carrying per-word error flags.

## Interface
- DATA_BITS, 8: data bits per frame, legal 5..9.
- OVERSAMPLE, 16: os_tick pulses per bit period; even, legal 8..32.
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- os_tick  in  1  one-cycle pulse at OVERSAMPLE × baud.
- rxd  in  1  asynchronous serial line, idle high.
- parity_en  in  1  1 = parity bit present.
- parity_odd  in  1  1 = odd parity, 0 = even parity.
- stop2  in  1  1 = two stop bits.
- m_data  out  DATA_BITS  received word, LSB first on the line.
- m_valid  out  1  word available.
- m_ready  in  1  consumer accepts the word.
- m_parity_err  out  1  parity mismatch; qualified by m_valid.
- m_frame_err  out  1  a stop bit sampled low; qualified by m_valid.
- overrun  out  1  one-cycle pulse when a completed frame is dropped.
- break_det  out  1  one-cycle pulse on a break frame.

## Operation
- rxd passes through a 2-flop synchronizer (rxd_s). Both flops reset to 1.
- All state advances only on cycles with os_tick=1. sample_cnt runs 0..OVERSAMPLE-1.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE: if rxd_s=0, go to START with sample_cnt=0. At the same point, latch parity_en, parity_odd and stop2; changes to these inputs mid-frame are ignored.
- START: when sample_cnt=OVERSAMPLE/2-1, check the mid-bit sample.
  - rxd_s=1: false start. Return to IDLE; no flags.
  - rxd_s=0: clear sample_cnt and go to DATA.
- DATA, PARITY, STOP: sample rxd_s at each sample_cnt=OVERSAMPLE-1, which is mid-bit.
  - DATA shifts DATA_BITS samples LSB-first into a shift register.
  - DATA goes to PARITY if the latched parity_en=1, otherwise to STOP.
- Parity check: expected bit = ^data XOR parity_odd. m_parity_err = sample != expected. It is 0 when parity is disabled.
- STOP samples 1 bit, or 2 when stop2=1. frame_err = any stop sample is 0.
- Frame completion happens at the last stop sample.
  - If m_valid=0, or m_valid=1 and m_ready=1 in that cycle: load m_data and the error flags, and assert m_valid.
  - Otherwise: drop the new frame, keep the held word, and pulse overrun.
- Break: all data bits 0, parity sample 0 (if enabled), and frame_err=1. Pulse break_det. The word is still delivered, with m_frame_err=1.
- After any frame with frame_err=1, go to WAIT_IDLE. Stay there until rxd_s=1 on an os_tick, then go to IDLE. Otherwise return to IDLE directly.
- Handshake: m_valid stays high and m_data and the flags stay stable until a cycle with m_ready=1.
  - m_ready with m_valid=0 has no effect.
  - Acceptance and a new completion in the same cycle: the new word loads and m_valid stays 1.

## Timing
- Reset values: m_data=0, m_valid=0, m_parity_err=0, m_frame_err=0, overrun=0, break_det=0, state IDLE, sample_cnt=0.
- Reset mid-frame aborts immediately. No word is delivered, and the next falling edge starts a fresh frame.
- Latency: m_valid rises the clk cycle after the os_tick carrying the last stop sample. overrun and break_det pulse in that same cycle.
- Start edge to first data sample: OVERSAMPLE/2 + OVERSAMPLE os_ticks, plus 2-cycle synchronizer delay.
- A frame occupies (1 + DATA_BITS + parity_en + 1 + stop2) bit periods, measured to the mid-point of the last stop bit. The receiver re-arms half a bit early.
- Back-to-back frames with no idle gap are received without loss.

## Configuration
- UART_RX_MAJORITY_EN defined: each bit value, including the start-bit check, is the 2-of-3 majority of rxd_s at sample_cnt mid-1, mid, mid+1. Here mid is OVERSAMPLE/2-1 for START and OVERSAMPLE-1 for other bits. Decisions occur at the mid+1 tick, delaying m_valid by one os_tick.
- Undefined: a single sample at mid, exactly as in Operation.

## Structure
- Package uart_pkg holds:
  - the rx_state_t enum (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE);
  - legal-range constants for DATA_BITS and OVERSAMPLE;
  - a parity helper function.
- Sub-module uart_sync2: reset-to-1 two-flop synchronizer, reusable by the TX loopback path.

## Test plan
- DATA_BITS=8, OVERSAMPLE=16, no parity, 1 stop; send 0xA5 → m_valid with m_data=0xA5, no error flags, held until m_ready.
- parity_en=1, parity_odd=0; send 0x3C with the parity bit forced to 1 → m_data=0x3C, m_parity_err=1.
- Low glitch of 4 os_ticks on an idle line → no m_valid; a following valid 0x55 frame is received correctly.
- stop2=1, second stop bit driven 0 → m_frame_err=1; receiver stays in WAIT_IDLE until rxd returns high.
- Line held low for 2 frame times → one word 0x00 with m_frame_err=1 and one break_det pulse; no further words until rxd goes high.
- m_ready=0; send 0x11 then 0x22 back-to-back → m_data stays 0x11, overrun pulses once at the end of 0x22.
